// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU opcodes, RISC-V funct3
// codes and the issue FSM state encoding.
package alu_pkg;

    // 3-bit opcodes understood by the downstream combinational ALU
    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_XOR = 3'b100;
    localparam logic [2:0] ALU_OP_SLL = 3'b101;
    localparam logic [2:0] ALU_OP_SRL = 3'b110;
    localparam logic [2:0] ALU_OP_SRA = 3'b111;

    // RISC-V OP / OP-IMM funct3 field values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Issue FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response signals of the ALU issue controller.
// The controller binds to the slave modport; its environment uses master.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    // decode -> controller request channel
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic              req_is_imm;
    logic [DATA_W-1:0] req_rs1;
    logic [DATA_W-1:0] req_rs2;
    logic [TAG_W-1:0]  req_tag;

    // controller <-> combinational ALU
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_op_0;
    logic [DATA_W-1:0] alu_op_1;
    logic [DATA_W-1:0] alu_out;

    // controller -> consumer response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_negative;
    logic              rsp_illegal;
    logic [TAG_W-1:0]  rsp_tag;

    modport slave (
        input  req_valid, req_funct3, req_funct7b5, req_is_imm, req_rs1, req_rs2, req_tag,
        output req_ready,
        output alu_opcode, alu_op_0, alu_op_1,
        input  alu_out,
        output rsp_valid, rsp_result, rsp_zero, rsp_negative, rsp_illegal, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_funct3, req_funct7b5, req_is_imm, req_rs1, req_rs2, req_tag,
        input  req_ready,
        input  alu_opcode, alu_op_0, alu_op_1,
        output alu_out,
        input  rsp_valid, rsp_result, rsp_zero, rsp_negative, rsp_illegal, rsp_tag,
        output rsp_ready
    );

endinterface

// File: rtl/alu_op_decode.sv
// Maps RISC-V funct3/funct7[5]/OP-IMM form onto the 3-bit ALU opcode.
// Build option: define ALU_SLT_EN to support SLT/SLTU (issued as SUB);
// without it those funct3 codes are flagged illegal and issued as ADD.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_imm,
    output logic [2:0] alu_opcode,
    output logic       is_slt,
    output logic       is_sltu,
    output logic       illegal
);

    // Pure decode table; funct7[5] only matters for ADD/SUB and SRL/SRA
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        alu_opcode = ALU_OP_ADD;
        is_slt     = 1'b0;
        is_sltu    = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_ADD_SUB: alu_opcode = (funct7b5 && !is_imm) ? ALU_OP_SUB : ALU_OP_ADD;
            F3_SLL:     alu_opcode = ALU_OP_SLL;
            F3_XOR:     alu_opcode = ALU_OP_XOR;
            F3_SRL_SRA: alu_opcode = funct7b5 ? ALU_OP_SRA : ALU_OP_SRL;
            F3_OR:      alu_opcode = ALU_OP_OR;
            F3_AND:     alu_opcode = ALU_OP_AND;
`ifdef ALU_SLT_EN
            F3_SLT: begin
                alu_opcode = ALU_OP_SUB;
                is_slt     = 1'b1;
            end
            F3_SLTU: begin
                alu_opcode = ALU_OP_SUB;
                is_sltu    = 1'b1;
            end
`else
            F3_SLT, F3_SLTU: illegal = 1'b1;
`endif
            default: alu_opcode = ALU_OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU interface: accepts a decoded integer op, drives
// the ALU operand buses for one settle cycle, then presents the registered
// result and flags on a valid/ready response port.
// Build option: ALU_SLT_EN (SLT/SLTU support, see alu_op_decode).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    alu_issue_ctrl_if.slave   bus
);

    localparam int MSB = DATA_W - 1;

    logic [1:0]        state;
    logic              accept;
    logic [2:0]        dec_opcode;
    logic              dec_slt;
    logic              dec_sltu;
    logic              dec_illegal;
    logic [TAG_W-1:0]  tag_q;
    logic              slt_q;
    logic              sltu_q;
    logic              illegal_q;
    logic              sign_diff;
    logic [DATA_W-1:0] result_d;

    alu_op_decode u_decode (
        .funct3     (bus.req_funct3),
        .funct7b5   (bus.req_funct7b5),
        .is_imm     (bus.req_is_imm),
        .alu_opcode (dec_opcode),
        .is_slt     (dec_slt),
        .is_sltu    (dec_sltu),
        .illegal    (dec_illegal)
    );

    // A new op may enter while idle, or in the same edge the held response drains
    assign bus.req_ready = (state == ST_IDLE) || ((state == ST_RESP) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // Issue FSM: IDLE -> EXEC (ALU settles) -> RESP (hold until consumed)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            case (state)
                ST_IDLE: if (accept) state <= ST_EXEC;
                ST_EXEC: state <= ST_RESP;
                ST_RESP: if (bus.rsp_ready) state <= accept ? ST_EXEC : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latch opcode, operands, tag and result kind when a request is accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.alu_opcode <= ALU_OP_ADD;
            bus.alu_op_0   <= '0;
            bus.alu_op_1   <= '0;
            tag_q          <= '0;
            slt_q          <= 1'b0;
            sltu_q         <= 1'b0;
            illegal_q      <= 1'b0;
        end else if (accept) begin
            bus.alu_opcode <= dec_opcode;
            bus.alu_op_0   <= bus.req_rs1;
            bus.alu_op_1   <= bus.req_rs2;
            tag_q          <= bus.req_tag;
            slt_q          <= dec_slt;
            sltu_q         <= dec_sltu;
            illegal_q      <= dec_illegal;
        end
    end

    // Final result: SLT/SLTU reduce the SUB output to one bit using the operand
    // signs to resolve overflow; illegal ops return zero
    always_comb begin
        sign_diff = bus.alu_op_0[MSB] ^ bus.alu_op_1[MSB];
        result_d  = bus.alu_out;
        if (illegal_q) begin
            result_d = '0;
        end else if (slt_q) begin
            result_d = {{(DATA_W-1){1'b0}}, sign_diff ? bus.alu_op_0[MSB] : bus.alu_out[MSB]};
        end else if (sltu_q) begin
            result_d = {{(DATA_W-1){1'b0}}, sign_diff ? bus.alu_op_1[MSB] : bus.alu_out[MSB]};
        end
    end

    // Capture result and flags at the end of EXEC; hold them until consumed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_negative <= 1'b0;
            bus.rsp_illegal  <= 1'b0;
            bus.rsp_tag      <= '0;
        end else if (state == ST_EXEC) begin
            bus.rsp_valid    <= 1'b1;
            bus.rsp_result   <= result_d;
            bus.rsp_zero     <= (result_d == '0);
            bus.rsp_negative <= result_d[MSB];
            bus.rsp_illegal  <= illegal_q;
            bus.rsp_tag      <= tag_q;
        end else if ((state == ST_RESP) && bus.rsp_ready) begin
            bus.rsp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written
// backpressure and reset sequences, then randomized back-to-back traffic
// checked against a RISC-V arithmetic reference model.
// Honours ALU_SLT_EN the same way the design does.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    alu_issue_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Combinational ALU the controller talks to
    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_opcode)
            3'b000: bus.alu_out = bus.alu_op_0 + bus.alu_op_1;
            3'b001: bus.alu_out = bus.alu_op_0 - bus.alu_op_1;
            3'b010: bus.alu_out = bus.alu_op_0 & bus.alu_op_1;
            3'b011: bus.alu_out = bus.alu_op_0 | bus.alu_op_1;
            3'b100: bus.alu_out = bus.alu_op_0 ^ bus.alu_op_1;
            3'b101: bus.alu_out = bus.alu_op_0 << bus.alu_op_1[4:0];
            3'b110: bus.alu_out = bus.alu_op_0 >> bus.alu_op_1[4:0];
            default: bus.alu_out = 32'($signed(bus.alu_op_0) >>> bus.alu_op_1[4:0]);
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural reference: what the RISC-V instruction computes
    typedef struct {
        logic [2:0]  opcode;
        logic [31:0] result;
        logic        illegal;
    } exp_t;

    function automatic exp_t model(input logic [2:0] f3, input logic f7b5, input logic imm,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.opcode  = 3'b000;
        e.result  = '0;
        e.illegal = 1'b0;
        case (f3)
            3'd0: if (f7b5 && !imm) begin e.opcode = 3'b001; e.result = a - b; end
                  else e.result = a + b;
            3'd1: begin e.opcode = 3'b101; e.result = a << b[4:0]; end
`ifdef ALU_SLT_EN
            3'd2: begin e.opcode = 3'b001; e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
            3'd3: begin e.opcode = 3'b001; e.result = (a < b) ? 32'd1 : 32'd0; end
`else
            3'd2, 3'd3: e.illegal = 1'b1;
`endif
            3'd4: begin e.opcode = 3'b100; e.result = a ^ b; end
            3'd5: if (f7b5) begin e.opcode = 3'b111; e.result = 32'($signed(a) >>> b[4:0]); end
                  else begin e.opcode = 3'b110; e.result = a >> b[4:0]; end
            3'd6: begin e.opcode = 3'b011; e.result = a | b; end
            default: begin e.opcode = 3'b010; e.result = a & b; end
        endcase
        return e;
    endfunction

    // Directed vectors with hand-computed expectations
    typedef struct {
        logic [2:0]  f3;
        logic        f7b5;
        logic        imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  exp_op;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_neg;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [2:0] f3, input logic f7b5, input logic imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [2:0] op, input logic [31:0] res,
                                 input logic z, input logic n, input logic il);
        vec_t v;
        v.f3 = f3; v.f7b5 = f7b5; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
        v.exp_op = op; v.exp_res = res; v.exp_zero = z; v.exp_neg = n; v.exp_ill = il;
        return v;
    endfunction

    // Present a request just after a clock edge and hold it until accepted.
    // Returns #1 after the accepting edge (controller then in its settle cycle).
    task automatic send(input logic [2:0] f3, input logic f7b5, input logic imm,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int waited;
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7b5;
        bus.req_is_imm   = imm;
        bus.req_rs1      = a;
        bus.req_rs2      = b;
        bus.req_tag      = tag;
        bus.req_valid    = 1'b1;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string nm, input logic [31:0] res, input logic ill,
                             input logic [3:0] tag);
        check({nm, "_valid"},  {31'd0, bus.rsp_valid},    32'd1);
        check({nm, "_result"}, bus.rsp_result,            res);
        check({nm, "_zero"},   {31'd0, bus.rsp_zero},     {31'd0, res == 32'd0});
        check({nm, "_neg"},    {31'd0, bus.rsp_negative}, {31'd0, res[31]});
        check({nm, "_ill"},    {31'd0, bus.rsp_illegal},  {31'd0, ill});
        check({nm, "_tag"},    {28'd0, bus.rsp_tag},      {28'd0, tag});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_res;
        exp_t        e;
        logic [2:0]  f3;
        logic        f7b5, imm;
        logic [31:0] a, b;
        int          stall;

        bus.req_valid    = 1'b0;
        bus.req_funct3   = '0;
        bus.req_funct7b5 = 1'b0;
        bus.req_is_imm   = 1'b0;
        bus.req_rs1      = '0;
        bus.req_rs2      = '0;
        bus.req_tag      = '0;
        bus.rsp_ready    = 1'b1;

        vecs.push_back(mkv(3'd0, 1'b0, 1'b0, 32'd5,        32'd7,        3'b000, 32'd12,       1'b0, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd0, 1'b1, 1'b0, 32'h1234,     32'h1234,     3'b001, 32'd0,        1'b1, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd0, 1'b1, 1'b1, 32'h1234,     32'h1234,     3'b000, 32'h2468,     1'b0, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd4,       3'b111, 32'hF800_0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkv(3'd5, 1'b0, 1'b1, 32'h8000_0000, 32'd4,       3'b110, 32'h0800_0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd0, 1'b1, 1'b0, 32'd3,        32'd5,        3'b001, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkv(3'd4, 1'b1, 1'b0, 32'hF0F0_0000, 32'h0FF0_FFFF, 3'b100, 32'hFF00_FFFF, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkv(3'd6, 1'b0, 1'b0, 32'h00FF_0000, 32'h0000_00FF, 3'b011, 32'h00FF_00FF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd7, 1'b0, 1'b1, 32'hFFFF_0000, 32'h00FF_FF00, 3'b010, 32'h00FF_0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd1, 1'b1, 1'b0, 32'd1,        32'h3F,       3'b101, 32'h8000_0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mkv(3'd5, 1'b1, 1'b0, 32'hF000_0000, 32'h24,      3'b111, 32'hFF00_0000, 1'b0, 1'b1, 1'b0));
`ifdef ALU_SLT_EN
        vecs.push_back(mkv(3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'b001, 32'd1,        1'b0, 1'b0, 1'b0));
        vecs.push_back(mkv(3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'b001, 32'd0,        1'b1, 1'b0, 1'b0));
`else
        vecs.push_back(mkv(3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'b000, 32'd0,        1'b1, 1'b0, 1'b1));
        vecs.push_back(mkv(3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       3'b000, 32'd0,        1'b1, 1'b0, 1'b1));
`endif

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("reset_rsp_result", bus.rsp_result,          32'd0);
        check("reset_rsp_tag",    {28'd0, bus.rsp_tag},    32'd0);
        check("reset_alu_opcode", {29'd0, bus.alu_opcode}, 32'd0);
        check("reset_alu_op_0",   bus.alu_op_0,            32'd0);
        check("reset_req_ready",  {31'd0, bus.req_ready},  32'd1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed table: settle cycle after accept, response after the next edge
        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            bus.rsp_ready = 1'b1;
            send(vecs[i].f3, vecs[i].f7b5, vecs[i].imm, vecs[i].rs1, vecs[i].rs2, 4'(i));
            check({nm, "_exec_valid"}, {31'd0, bus.rsp_valid},  32'd0);
            check({nm, "_exec_ready"}, {31'd0, bus.req_ready},  32'd0);
            check({nm, "_opcode"},     {29'd0, bus.alu_opcode}, {29'd0, vecs[i].exp_op});
            check({nm, "_op_0"},       bus.alu_op_0,            vecs[i].rs1);
            check({nm, "_op_1"},       bus.alu_op_1,            vecs[i].rs2);
            @(posedge clock); #1;
            check_rsp(nm, vecs[i].exp_res, vecs[i].exp_ill, 4'(i));
            check({nm, "_zero_tbl"}, {31'd0, bus.rsp_zero},     {31'd0, vecs[i].exp_zero});
            check({nm, "_neg_tbl"},  {31'd0, bus.rsp_negative}, {31'd0, vecs[i].exp_neg});
            @(posedge clock); #1;
            check({nm, "_drained"}, {31'd0, bus.rsp_valid}, 32'd0);
        end

        // Backpressure: response held for 5 cycles, then drain and accept on the same edge
        send(3'd0, 1'b0, 1'b0, 32'd100, 32'd23, 4'hA);
        bus.rsp_ready = 1'b0;
        @(posedge clock); #1;
        check_rsp("bp_first", 32'd123, 1'b0, 4'hA);
        bus.req_funct3   = 3'd4;
        bus.req_funct7b5 = 1'b0;
        bus.req_is_imm   = 1'b0;
        bus.req_rs1      = 32'hAAAA_5555;
        bus.req_rs2      = 32'hFFFF_FFFF;
        bus.req_tag      = 4'hB;
        bus.req_valid    = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(posedge clock); #1;
            check_rsp($sformatf("bp_hold%0d", s), 32'd123, 1'b0, 4'hA);
            check($sformatf("bp_hold%0d_req_ready", s), {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_req_ready_on_drain", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        check("bp_second_exec_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_second_op_0",       bus.alu_op_0,           32'hAAAA_5555);
        @(posedge clock); #1;
        check_rsp("bp_second", 32'h5555_AAAA, 1'b0, 4'hB);
        @(posedge clock); #1;

        // Reset asserted during the settle cycle: everything clears at once
        send(3'd0, 1'b1, 1'b0, 32'd9, 32'd2, 4'h9);
        reset_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid",  {31'd0, bus.rsp_valid},    32'd0);
        check("rst_mid_rsp_result", bus.rsp_result,            32'd0);
        check("rst_mid_rsp_neg",    {31'd0, bus.rsp_negative}, 32'd0);
        check("rst_mid_rsp_tag",    {28'd0, bus.rsp_tag},      32'd0);
        check("rst_mid_alu_opcode", {29'd0, bus.alu_opcode},   32'd0);
        check("rst_mid_alu_op_0",   bus.alu_op_0,              32'd0);
        check("rst_mid_alu_op_1",   bus.alu_op_1,              32'd0);
        check("rst_mid_req_ready",  {31'd0, bus.req_ready},    32'd1);
        repeat (2) @(posedge clock);
        #1;
        check("rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_after_release_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        send(3'd0, 1'b0, 1'b1, 32'd40, 32'd2, 4'h3);
        @(posedge clock); #1;
        check_rsp("rst_recover", 32'd42, 1'b0, 4'h3);

        // Randomized back-to-back traffic with random response stalls
        for (int i = 0; i < 200; i++) begin
            string nm;
            nm    = $sformatf("rnd%0d", i);
            f3    = 3'($urandom_range(0, 7));
            f7b5  = 1'($urandom);
            imm   = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'h7FFF_FFFF;
                default: b = $urandom;
            endcase
            stall = $urandom_range(0, 3);
            e = model(f3, f7b5, imm, a, b);
            bus.rsp_ready = 1'b1;
            send(f3, f7b5, imm, a, b, 4'(i));
            bus.rsp_ready = (stall == 0);
            check({nm, "_exec_valid"}, {31'd0, bus.rsp_valid},  32'd0);
            check({nm, "_opcode"},     {29'd0, bus.alu_opcode}, {29'd0, e.opcode});
            @(posedge clock); #1;
            check_rsp(nm, e.result, e.illegal, 4'(i));
            held_res = e.result;
            for (int s = 0; s < stall; s++) begin
                @(posedge clock); #1;
                check({nm, "_stall_result"}, bus.rsp_result,        held_res);
                check({nm, "_stall_valid"},  {31'd0, bus.rsp_valid}, 32'd1);
            end
            bus.rsp_ready = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
                check({nm, "_drained"}, {31'd0, bus.rsp_valid}, 32'd0);
            end
        end

        @(posedge clock); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
